mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 63 ++++++
 rtl/mem_access_load_ext.sv | 35 +++
 rtl/mem_access.sv | 123 ++++++++++++
 tb/tb_mem_access.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the M-stage memory access block: op and FSM encodings,
// default bus timeout, and lane/alignment helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  function automatic logic is_load(input op_e op);
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input op_e op);
    case (op)
      OP_SW, OP_SH, OP_SB: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input op_e op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return (lo == 2'b00);
      OP_LH, OP_LHU, OP_SH: return !lo[0];
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input op_e op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[1] ? 4'b1100 : 4'b0011;
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << lo;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input op_e op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Selects the addressed byte/halfword lane of the bus read word and
// sign- or zero-extends it according to the load op.
module load_ext
  import mem_access_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdt,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (lane)
      2'd0:    sel_b = rdt[7:0];
      2'd1:    sel_b = rdt[15:8];
      2'd2:    sel_b = rdt[23:16];
      default: sel_b = rdt[31:24];
    endcase
    sel_h = lane[1] ? rdt[31:16] : rdt[15:0];
  end

  always_comb begin
    case (op)
      OP_LB:   data = {{24{sel_b[7]}}, sel_b};
      OP_LBU:  data = {24'd0, sel_b};
      OP_LH:   data = {{16{sel_h[15]}}, sel_h};
      OP_LHU:  data = {16'd0, sel_h};
      default: data = rdt;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M-stage memory access controller: aligns and issues one bus access per op,
// stalls the pipeline until ack or timeout, and extends load data for W.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        mem_access_clk_M_i,
  input  logic        mem_access_rstn_M_i,
  input  logic        mem_access_vld_M_i,
  input  logic [3:0]  mem_access_op_M_i,
  input  logic [31:0] mem_access_alo_M_i,
  input  logic [31:0] mem_access_rtd_M_i,
  input  logic        mem_access_clr_M_i,
  output logic        mem_access_req_M_o,
  output logic        mem_access_we_M_o,
  output logic [31:0] mem_access_adr_M_o,
  output logic [3:0]  mem_access_be_M_o,
  output logic [31:0] mem_access_wdt_M_o,
  input  logic        mem_access_ack_M_i,
  input  logic [31:0] mem_access_rdt_M_i,
  output logic        mem_access_stall_M_o,
  output logic [31:0] mem_access_dmd_M_o,
  output logic        mem_access_adel_M_o,
  output logic        mem_access_ades_M_o,
  output logic        mem_access_berr_M_o
);

  state_e      state;
  op_e         op_in;
  op_e         op_q;
  logic [1:0]  lane_q;
  logic [7:0]  wait_cnt;
  logic        we_q;
  logic        berr_q;
  logic [31:0] adr_q;
  logic [31:0] wdt_q;
  logic [31:0] dmd_q;
  logic [3:0]  be_q;
  logic [31:0] ext_data;
  logic        live;
  logic        aligned;
  logic        accept;
  logic        misalign;
  logic        timeout;

  assign op_in = op_e'(mem_access_op_M_i);

  // Input-dependent outputs are gated by reset so they read 0 while it is held.
  always_comb begin
    live     = mem_access_rstn_M_i && (state == ST_IDLE) && mem_access_vld_M_i &&
               !mem_access_clr_M_i && (is_load(op_in) || is_store(op_in));
    aligned  = is_aligned(op_in, mem_access_alo_M_i[1:0]);
    accept   = live && aligned;
    misalign = live && !aligned;
    // Last permitted wait cycle without ack; berr is registered so it shows in DONE.
    timeout  = (state == ST_REQ) && !mem_access_ack_M_i && (wait_cnt == 8'(TIMEOUT - 1));
  end

  load_ext u_load_ext (
    .op   (op_q),
    .lane (lane_q),
    .rdt  (mem_access_rdt_M_i),
    .data (ext_data)
  );

  always_ff @(posedge mem_access_clk_M_i or negedge mem_access_rstn_M_i) begin
    if (!mem_access_rstn_M_i) begin
      state    <= ST_IDLE;
      op_q     <= OP_NONE;
      lane_q   <= '0;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      berr_q   <= 1'b0;
      adr_q    <= '0;
      wdt_q    <= '0;
      dmd_q    <= '0;
      be_q     <= '0;
    end else begin
      berr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_REQ;
            adr_q    <= {mem_access_alo_M_i[31:2], 2'b00};
            be_q     <= byte_en(op_in, mem_access_alo_M_i[1:0]);
            we_q     <= is_store(op_in);
            wdt_q    <= lane_wdata(op_in, mem_access_rtd_M_i);
            op_q     <= op_in;
            lane_q   <= mem_access_alo_M_i[1:0];
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (mem_access_ack_M_i) begin
            if (is_load(op_q)) dmd_q <= ext_data;
            state <= ST_DONE;
          end else if (timeout) begin
            berr_q <= 1'b1;
            if (is_load(op_q)) dmd_q <= '0;
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_access_req_M_o   = (state == ST_REQ);
  assign mem_access_we_M_o    = we_q;
  assign mem_access_adr_M_o   = adr_q;
  assign mem_access_be_M_o    = be_q;
  assign mem_access_wdt_M_o   = wdt_q;
  assign mem_access_stall_M_o = accept || (state == ST_REQ);
  assign mem_access_dmd_M_o   = dmd_q;
  assign mem_access_adel_M_o  = misalign && is_load(op_in);
  assign mem_access_ades_M_o  = misalign && is_store(op_in);
  assign mem_access_berr_M_o  = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus/response records,
// a negedge monitor pops and compares them as the DUT presents activity.
module tb_mem_access;

  localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                         LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;
  localparam int K_BUS = 0, K_ADEL = 1, K_ADES = 2, K_ABORT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [3:0]  op;
  logic [31:0] alo;
  logic [31:0] rtd;
  logic        clr;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  be;
  logic [31:0] wdt;
  logic        ack;
  logic [31:0] rdt;
  logic        stall;
  logic [31:0] dmd;
  logic        adel;
  logic        ades;
  logic        berr;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .mem_access_clk_M_i   (clk),
    .mem_access_rstn_M_i  (rst_n),
    .mem_access_vld_M_i   (vld),
    .mem_access_op_M_i    (op),
    .mem_access_alo_M_i   (alo),
    .mem_access_rtd_M_i   (rtd),
    .mem_access_clr_M_i   (clr),
    .mem_access_req_M_o   (req),
    .mem_access_we_M_o    (we),
    .mem_access_adr_M_o   (adr),
    .mem_access_be_M_o    (be),
    .mem_access_wdt_M_o   (wdt),
    .mem_access_ack_M_i   (ack),
    .mem_access_rdt_M_i   (rdt),
    .mem_access_stall_M_o (stall),
    .mem_access_dmd_M_o   (dmd),
    .mem_access_adel_M_o  (adel),
    .mem_access_ades_M_o  (ades),
    .mem_access_berr_M_o  (berr)
  );

  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdt;
    logic        chk_wdt;
    logic [31:0] dmd;
    logic        berr;
    int          req_cycles;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [3:0] b, input logic w,
                      input logic [31:0] wd, input logic cw, input logic [31:0] dm,
                      input logic be_r, input int rc);
    exp_t e;
    e.kind = kind; e.adr = a; e.be = b; e.we = w; e.wdt = wd; e.chk_wdt = cw;
    e.dmd = dm; e.berr = be_r; e.req_cycles = rc;
    q.push_back(e);
  endtask

  // Monitor
  exp_t cur;
  exp_t mis;
  bit   in_txn = 1'b0;
  bit   done_next = 1'b0;
  int   reqc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_txn) begin
        chk("abort_kind", cur.kind, K_ABORT);
        chk("abort_req", {31'd0, req}, 0);
        chk("abort_berr", {31'd0, berr}, 0);
        in_txn = 1'b0;
        done_next = 1'b0;
      end
    end else if (in_txn) begin
      if (done_next) begin
        chk("done_dmd", dmd, cur.dmd);
        chk("done_berr", {31'd0, berr}, {31'd0, cur.berr});
        chk("req_cycles", reqc, cur.req_cycles);
        in_txn = 1'b0;
        done_next = 1'b0;
      end else if (req) begin
        reqc++;
        chk("held_adr", adr, cur.adr);
        if (ack) done_next = 1'b1;
      end else begin
        chk("timeout_berr", {31'd0, berr}, {31'd0, cur.berr});
        chk("timeout_dmd", dmd, cur.dmd);
        chk("req_cycles", reqc, cur.req_cycles);
        in_txn = 1'b0;
      end
    end else begin
      if (berr) chk("spurious_berr", {31'd0, berr}, 0);
      if (req) begin
        if (q.size() == 0) chk("spurious_req", {31'd0, req}, 0);
        else begin
          cur = q.pop_front();
          if (cur.kind == K_ADEL || cur.kind == K_ADES) chk("req_on_misalign", {31'd0, req}, 0);
          chk("bus_adr", adr, cur.adr);
          chk("bus_be", {28'd0, be}, {28'd0, cur.be});
          chk("bus_we", {31'd0, we}, {31'd0, cur.we});
          if (cur.chk_wdt) chk("bus_wdt", wdt, cur.wdt);
          in_txn = 1'b1;
          reqc = 1;
          if (ack) done_next = 1'b1;
        end
      end else if (adel || ades) begin
        if (q.size() == 0) chk("spurious_flag", {30'd0, adel, ades}, 0);
        else begin
          mis = q.pop_front();
          chk("adel", {31'd0, adel}, (mis.kind == K_ADEL) ? 1 : 0);
          chk("ades", {31'd0, ades}, (mis.kind == K_ADES) ? 1 : 0);
          chk("misalign_stall", {31'd0, stall}, 0);
        end
      end
    end
  end

  // clr_mode: 0 none, 1 with the op (blocks it), 2 held through the bus access
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r, input int ack_after, input int clr_mode,
                       input int exp_stalls);
    int stalls;
    int c;
    stalls = 0;
    vld = 1'b1; op = o; alo = a; rtd = d; rdt = r; ack = 1'b0;
    clr = (clr_mode == 1);
    @(negedge clk);
    if (stall) stalls++;
    @(posedge clk); #1;
    vld = 1'b0; op = NONE; clr = (clr_mode == 2);
    for (c = 0; c < 40; c++) begin
      ack = (ack_after >= 0) && (c >= ack_after);
      @(negedge clk);
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    if (c == 40) chk("op_cycle_bound", {31'd0, stall}, 0);
    chk("stall_cycles", stalls, exp_stalls);
    @(posedge clk); #1;
    ack = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; op = NONE; alo = '0; rtd = '0; clr = 1'b0; ack = 1'b0; rdt = '0;
    repeat (2) @(posedge clk); #1;
    vld = 1'b1; op = LW; alo = 32'h1000;
    #1;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_be", {28'd0, be}, 0);
    chk("rst_wdt", wdt, 0);
    chk("rst_dmd", dmd, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_flags", {29'd0, adel, ades, berr}, 0);
    vld = 1'b0; op = NONE;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    push(K_BUS, 32'h1004, 4'b1111, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1);
    do_op(LW, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 0, 2);
    push(K_BUS, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1);
    do_op(LB, 32'h1003, 32'h0, 32'h80FF0000, 0, 0, 2);
    push(K_BUS, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b0, 32'h00000080, 1'b0, 1);
    do_op(LBU, 32'h1003, 32'h0, 32'h80FF0000, 0, 0, 2);
    push(K_BUS, 32'h2000, 4'b1100, 1'b1, 32'hABCDABCD, 1'b1, 32'h00000080, 1'b0, 1);
    do_op(SH, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0, 2);
    push(K_BUS, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b0, 32'hFFFF8001, 1'b0, 1);
    do_op(LH, 32'h1002, 32'h0, 32'h80017FFF, 0, 0, 2);
    push(K_BUS, 32'h1000, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h00008765, 1'b0, 1);
    do_op(LHU, 32'h1000, 32'h0, 32'h12348765, 0, 0, 2);
    push(K_BUS, 32'h1000, 4'b0010, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h00008765, 1'b0, 1);
    do_op(SB, 32'h1001, 32'h123456A5, 32'h0, 0, 0, 2);
    push(K_BUS, 32'h0010, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b1, 32'h00008765, 1'b0, 1);
    do_op(SW, 32'h0010, 32'hCAFEF00D, 32'h0, 0, 0, 2);
    push(K_ADEL, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    do_op(LW, 32'h1002, 32'h0, 32'h0, -1, 0, 0);
    push(K_ADES, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    do_op(SH, 32'h2001, 32'h0, 32'h0, -1, 0, 0);
    do_op(LW, 32'h0040, 32'h0, 32'h0, 0, 1, 0);
    chk("dmd_after_clr", dmd, 32'h00008765);
    push(K_BUS, 32'h0020, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h11223344, 1'b0, 3);
    do_op(LW, 32'h0020, 32'h0, 32'h11223344, 2, 0, 4);
    push(K_BUS, 32'h3000, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 4);
    do_op(LW, 32'h3000, 32'h0, 32'h0, -1, 0, 5);
    push(K_BUS, 32'h0024, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h55667788, 1'b0, 4);
    do_op(LW, 32'h0024, 32'h0, 32'h55667788, 3, 0, 5);
    push(K_BUS, 32'h1000, 4'b0010, 1'b0, 32'h0, 1'b0, 32'h0000007F, 1'b0, 2);
    do_op(LB, 32'h1001, 32'h0, 32'h00007F00, 1, 2, 3);

    // Reset in the middle of a held bus access
    push(K_ABORT, 32'h3000, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    vld = 1'b1; op = LW; alo = 32'h3000; ack = 1'b0;
    @(posedge clk); #1;
    vld = 1'b0; op = NONE;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midreq_rst_req", {31'd0, req}, 0);
    chk("midreq_rst_stall", {31'd0, stall}, 0);
    chk("midreq_rst_berr", {31'd0, berr}, 0);
    chk("midreq_rst_adr", adr, 0);
    chk("midreq_rst_dmd", dmd, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_berr", {31'd0, berr}, 0);
      chk("post_rst_req", {31'd0, req}, 0);
    end
    @(posedge clk); #1;
    push(K_BUS, 32'h1004, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0BADF00D, 1'b0, 1);
    do_op(LW, 32'h1004, 32'h0, 32'h0BADF00D, 0, 0, 2);

    chk("queue_drained", q.size(), 0);
    chk("txn_closed", {31'd0, in_txn}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
